// File: rtl/game_control_pkg.sv
// Shared definitions for the Reversi game control FSM: state codes,
// cursor direction encoding, key bit positions and the wait-state predicate.
package game_control_pkg;

  localparam logic [3:0] S_RESET      = 4'd0;
  localparam logic [3:0] S_DRAW_BOARD = 4'd1;
  localparam logic [3:0] S_DRAW_INIT  = 4'd2;
  localparam logic [3:0] S_HIGHLIGHT  = 4'd3;
  localparam logic [3:0] S_IDLE       = 4'd4;
  localparam logic [3:0] S_MOVE       = 4'd5;
  localparam logic [3:0] S_CHECK      = 4'd6;
  localparam logic [3:0] S_PLACE      = 4'd7;
  localparam logic [3:0] S_FLIP       = 4'd8;
  localparam logic [3:0] S_SCORE      = 4'd9;
  localparam logic [3:0] S_TURN       = 4'd10;
  localparam logic [3:0] S_HAS_CUR    = 4'd11;
  localparam logic [3:0] S_HAS_OPP    = 4'd12;
  localparam logic [3:0] S_REMOVE_HL  = 4'd13;
  localparam logic [3:0] S_GAME_OVER  = 4'd14;

  localparam logic [1:0] DIR_RIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  // Bit positions inside the 5-bit key vector.
  localparam int unsigned KEY_ENTER = 0;
  localparam int unsigned KEY_RIGHT = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_UP    = 3;
  localparam int unsigned KEY_DOWN  = 4;

  // States that hold their enable until the datapath answers with go.
  function automatic logic isWaitState(input logic [3:0] s);
    return s inside {S_DRAW_BOARD, S_DRAW_INIT, S_HIGHLIGHT, S_CHECK, S_PLACE,
                     S_FLIP, S_SCORE, S_HAS_CUR, S_HAS_OPP, S_REMOVE_HL};
  endfunction

endpackage

// File: rtl/game_control_key_edge_detect.sv
// Push-button press detector: registers the key levels and produces a
// registered one-cycle event on each rising level.
module key_edge_detect (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] keys,
  output logic [4:0] keyLevel,
  output logic [4:0] keyEvent
);

  // Level history and rising-edge events, both cleared by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      keyLevel <= '0;
      keyEvent <= '0;
    end else begin
      keyLevel <= keys;
      keyEvent <= keys & ~keyLevel;
    end
  end

endmodule

// File: rtl/game_control.sv
// Reversi game control FSM: sequences datapath enables one at a time over
// the enable/go handshake and turns key presses into cursor/placement flow.
// Optional watchdog on every go-wait state: define GAME_CONTROL_TIMEOUT_EN.
module game_control
  import game_control_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_enter,
  input  logic       key_right,
  input  logic       key_left,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       go,
  input  logic       valid_move,
  input  logic       has_turn,
  output logic       write_en,
  output logic       draw_board_en,
  output logic       draw_initial_pieces_en,
  output logic       move_highlight_en,
  output logic       check_valid_move_en,
  output logic       place_en,
  output logic       flip_en,
  output logic       score_manager_en,
  output logic       determine_has_turn_en,
  output logic       turn_manager_en,
  output logic       remove_highlight_en,
  output logic       move_right_en,
  output logic       move_left_en,
  output logic       move_up_en,
  output logic       move_down_en,
  output logic       determine_current,
  output logic       determine_opponent,
  output logic       new_game,
  output logic       game_over,
  output logic       timeout_err,
  output logic [3:0] state_o
);

  logic [3:0] state, nextState;
  logic [1:0] dir, nextDir;
  logic       newGame;
  logic [4:0] keyEvent;
  logic [4:0] unusedKeyLevel;
  logic       goEff, validEff, hasEff;

  key_edge_detect keyEdge (
    .clk      (clk),
    .resetn   (resetn),
    .keys     ({key_down, key_up, key_left, key_right, key_enter}),
    .keyLevel (unusedKeyLevel),
    .keyEvent (keyEvent)
  );

`ifdef GAME_CONTROL_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] waitCnt;
  logic             tmo;
  logic             timeoutErr;

  // A wait state that has already spent TIMEOUT_CYCLES-1 cycles advances on
  // this edge, so the watchdog trips after exactly TIMEOUT_CYCLES cycles.
  assign tmo      = isWaitState(state) && (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign goEff    = go | tmo;
  assign validEff = valid_move & ~tmo;
  assign hasEff   = has_turn & ~tmo;
  assign timeout_err = timeoutErr;

  // Per-state wait counter, restarted on every state change.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      waitCnt <= '0;
    end else if (nextState != state) begin
      waitCnt <= '0;
    end else if (isWaitState(state)) begin
      waitCnt <= waitCnt + CNT_W'(1);
    end
  end

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timeoutErr <= 1'b0;
    end else if (tmo) begin
      timeoutErr <= 1'b1;
    end
  end
`else
  logic unusedCfg;
  assign unusedCfg   = ^TIMEOUT_CYCLES;
  assign goEff       = go;
  assign validEff    = valid_move;
  assign hasEff      = has_turn;
  assign timeout_err = 1'b0;
`endif

  // State, latched direction and the restart pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_RESET;
      dir     <= DIR_RIGHT;
      newGame <= 1'b0;
    end else begin
      state   <= nextState;
      dir     <= nextDir;
      newGame <= (state == S_GAME_OVER) && keyEvent[KEY_ENTER];
    end
  end

  // Next-state logic; key events only matter in IDLE and GAME_OVER.
  always_comb begin
    nextState = state;
    nextDir   = dir;
    case (state)
      S_RESET:      nextState = S_DRAW_BOARD;
      S_DRAW_BOARD: if (goEff) nextState = S_DRAW_INIT;
      S_DRAW_INIT:  if (goEff) nextState = S_HIGHLIGHT;
      S_HIGHLIGHT:  if (goEff) nextState = S_IDLE;
      S_IDLE: begin
        if (keyEvent[KEY_ENTER]) begin
          nextState = S_CHECK;
        end else if (keyEvent[KEY_RIGHT]) begin
          nextState = S_MOVE;
          nextDir   = DIR_RIGHT;
        end else if (keyEvent[KEY_LEFT]) begin
          nextState = S_MOVE;
          nextDir   = DIR_LEFT;
        end else if (keyEvent[KEY_UP]) begin
          nextState = S_MOVE;
          nextDir   = DIR_UP;
        end else if (keyEvent[KEY_DOWN]) begin
          nextState = S_MOVE;
          nextDir   = DIR_DOWN;
        end
      end
      S_MOVE:       nextState = S_HIGHLIGHT;
      S_CHECK:      if (goEff) nextState = validEff ? S_PLACE : S_IDLE;
      S_PLACE:      if (goEff) nextState = S_FLIP;
      S_FLIP:       if (goEff) nextState = S_SCORE;
      S_SCORE:      if (goEff) nextState = S_TURN;
      S_TURN:       nextState = S_HAS_CUR;
      S_HAS_CUR:    if (goEff) nextState = hasEff ? S_HIGHLIGHT : S_HAS_OPP;
      S_HAS_OPP:    if (goEff) nextState = hasEff ? S_TURN : S_REMOVE_HL;
      S_REMOVE_HL:  if (goEff) nextState = S_GAME_OVER;
      S_GAME_OVER:  if (keyEvent[KEY_ENTER]) nextState = S_DRAW_BOARD;
      default:      nextState = S_RESET;
    endcase
  end

  // Moore output decode from the state register.
  always_comb begin
    write_en               = 1'b0;
    draw_board_en          = 1'b0;
    draw_initial_pieces_en = 1'b0;
    move_highlight_en      = 1'b0;
    check_valid_move_en    = 1'b0;
    place_en               = 1'b0;
    flip_en                = 1'b0;
    score_manager_en       = 1'b0;
    determine_has_turn_en  = 1'b0;
    turn_manager_en        = 1'b0;
    remove_highlight_en    = 1'b0;
    move_right_en          = 1'b0;
    move_left_en           = 1'b0;
    move_up_en             = 1'b0;
    move_down_en           = 1'b0;
    determine_current      = 1'b0;
    determine_opponent     = 1'b0;
    game_over              = 1'b0;
    case (state)
      S_DRAW_BOARD: begin draw_board_en = 1'b1;          write_en = 1'b1; end
      S_DRAW_INIT:  begin draw_initial_pieces_en = 1'b1; write_en = 1'b1; end
      S_HIGHLIGHT:  begin move_highlight_en = 1'b1;      write_en = 1'b1; end
      S_MOVE: begin
        case (dir)
          DIR_RIGHT: move_right_en = 1'b1;
          DIR_LEFT:  move_left_en  = 1'b1;
          DIR_UP:    move_up_en    = 1'b1;
          default:   move_down_en  = 1'b1;
        endcase
      end
      S_CHECK:      check_valid_move_en = 1'b1;
      S_PLACE:      begin place_en = 1'b1; write_en = 1'b1; end
      S_FLIP:       begin flip_en  = 1'b1; write_en = 1'b1; end
      S_SCORE:      score_manager_en = 1'b1;
      S_TURN:       turn_manager_en  = 1'b1;
      S_HAS_CUR:    begin determine_has_turn_en = 1'b1; determine_current  = 1'b1; end
      S_HAS_OPP:    begin determine_has_turn_en = 1'b1; determine_opponent = 1'b1; end
      S_REMOVE_HL:  begin remove_highlight_en = 1'b1; write_en = 1'b1; end
      S_GAME_OVER:  game_over = 1'b1;
      default: ;
    endcase
  end

  assign new_game = newGame;
  assign state_o  = state;

endmodule

// File: tb/tb_game_control.sv
// Scoreboard bench for game_control: a driver plays a randomized datapath and
// key pad, pushing the expected output vector and cycle of every change; a
// monitor compares each observed output change against the queue head.
`timescale 1ns/1ps
module tb_game_control;
  import game_control_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic [4:0] keyDrv;
  logic key_enter, key_right, key_left, key_up, key_down;
  logic go, valid_move, has_turn;
  logic write_en, draw_board_en, draw_initial_pieces_en, move_highlight_en;
  logic check_valid_move_en, place_en, flip_en, score_manager_en;
  logic determine_has_turn_en, turn_manager_en, remove_highlight_en;
  logic move_right_en, move_left_en, move_up_en, move_down_en;
  logic determine_current, determine_opponent, new_game, game_over, timeout_err;
  logic [3:0] state_o;

  assign key_enter = keyDrv[0];
  assign key_right = keyDrv[1];
  assign key_left  = keyDrv[2];
  assign key_up    = keyDrv[3];
  assign key_down  = keyDrv[4];

  always #5 clk = ~clk;

  game_control #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .key_enter(key_enter), .key_right(key_right), .key_left(key_left),
    .key_up(key_up), .key_down(key_down),
    .go(go), .valid_move(valid_move), .has_turn(has_turn),
    .write_en(write_en), .draw_board_en(draw_board_en),
    .draw_initial_pieces_en(draw_initial_pieces_en),
    .move_highlight_en(move_highlight_en), .check_valid_move_en(check_valid_move_en),
    .place_en(place_en), .flip_en(flip_en), .score_manager_en(score_manager_en),
    .determine_has_turn_en(determine_has_turn_en), .turn_manager_en(turn_manager_en),
    .remove_highlight_en(remove_highlight_en),
    .move_right_en(move_right_en), .move_left_en(move_left_en),
    .move_up_en(move_up_en), .move_down_en(move_down_en),
    .determine_current(determine_current), .determine_opponent(determine_opponent),
    .new_game(new_game), .game_over(game_over), .timeout_err(timeout_err),
    .state_o(state_o)
  );

  // Observed vector: 19 terr, 18 new_game, 17 game_over, 16 write_en, 15 board,
  // 14 init, 13 highlight, 12..9 R/L/U/D, 8 check, 7 place, 6 flip, 5 score,
  // 4 turn, 3 determine, 2 current, 1 opponent, 0 remove_highlight.
  logic [19:0] obs;
  assign obs = {timeout_err, new_game, game_over, write_en, draw_board_en,
                draw_initial_pieces_en, move_highlight_en, move_right_en,
                move_left_en, move_up_en, move_down_en, check_valid_move_en,
                place_en, flip_en, score_manager_en, turn_manager_en,
                determine_has_turn_en, determine_current, determine_opponent,
                remove_highlight_en};

  typedef enum int {OP_RESET, OP_BOARD, OP_INIT, OP_HL, OP_IDLE, OP_MOVE, OP_CHECK,
                    OP_PLACE, OP_FLIP, OP_SCORE, OP_TURN, OP_CUR, OP_OPP, OP_REM,
                    OP_OVER} op_e;

  typedef struct {
    logic [19:0] vec;
    int          t;
    int          st;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   monOn = 1'b0;
  logic [19:0] prevObs = '0;
  logic terrExp = 1'b0;

  op_e op;
  int  tE;
  int  dir = 0;
  int  games = 0;
  int  nOps = 0;
  bit  passed = 1'b0;
  bit  ng = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs of each datapath operation.
  function automatic logic [19:0] opVec(input op_e o, input int d);
    logic [19:0] v;
    v = '0;
    case (o)
      OP_BOARD: begin v[16] = 1'b1; v[15] = 1'b1; end
      OP_INIT:  begin v[16] = 1'b1; v[14] = 1'b1; end
      OP_HL:    begin v[16] = 1'b1; v[13] = 1'b1; end
      OP_MOVE:  v[12 - d] = 1'b1;
      OP_CHECK: v[8] = 1'b1;
      OP_PLACE: begin v[16] = 1'b1; v[7] = 1'b1; end
      OP_FLIP:  begin v[16] = 1'b1; v[6] = 1'b1; end
      OP_SCORE: v[5] = 1'b1;
      OP_TURN:  v[4] = 1'b1;
      OP_CUR:   begin v[3] = 1'b1; v[2] = 1'b1; end
      OP_OPP:   begin v[3] = 1'b1; v[1] = 1'b1; end
      OP_REM:   begin v[16] = 1'b1; v[0] = 1'b1; end
      OP_OVER:  v[17] = 1'b1;
      default: ;
    endcase
    v[19] = terrExp;
    return v;
  endfunction

  task automatic pushExp(input logic [19:0] v, input int t, input int st);
    exp_t e;
    e.vec = v;
    e.t   = t;
    e.st  = st;
    q.push_back(e);
  endtask

  task automatic pushOp(input op_e o, input int t);
    int st;
    st = (o == OP_IDLE) ? int'(S_IDLE) : (o == OP_OVER) ? int'(S_GAME_OVER) : -1;
    pushExp(opVec(o, dir), t, st);
  endtask

  // Advance to the falling edge of cycle t, scrambling the don't-care inputs.
  task automatic goTo(input int t, input bit goNoise);
    while (cyc < t) begin
      @(negedge clk);
      go         = goNoise ? 1'($urandom_range(0, 1)) : 1'b0;
      valid_move = 1'($urandom_range(0, 1));
      has_turn   = 1'($urandom_range(0, 1));
    end
  endtask

  // Play one operation of the game flow starting at entry cycle tE.
  task automatic runOp();
    int w;
    int h;
    logic [4:0] k;
    op_e nxt;
    nOps++;
    case (op)
      OP_IDLE: begin
        goTo(tE, 1'b1);
        keyDrv = '0;
        w = $urandom_range(1, 3);
        goTo(tE + w, 1'b1);
        k = 5'($urandom_range(1, 31));
        keyDrv = k;
        if (k[0]) nxt = OP_CHECK;
        else begin
          nxt = OP_MOVE;
          dir = k[1] ? 0 : k[2] ? 1 : k[3] ? 2 : 3;
        end
        tE = tE + w + 2;
        op = nxt;
        pushOp(op, tE);
      end
      OP_MOVE: begin
        tE = tE + 1; op = OP_HL; pushOp(op, tE);
      end
      OP_TURN: begin
        tE = tE + 1; op = OP_CUR; pushOp(op, tE);
      end
      OP_OVER: begin
        goTo(tE, 1'b1);
        keyDrv = '0;
        w = $urandom_range(1, 3);
        goTo(tE + w, 1'b1);
        keyDrv = {4'($urandom_range(0, 15)), 1'b0};
        goTo(tE + w + 1, 1'b1);
        keyDrv = '0;
        goTo(tE + w + 3, 1'b1);
        keyDrv = 5'b00001;
        tE = tE + w + 5;
        op = OP_BOARD;
        ng = 1'b1;
        pushExp(opVec(OP_BOARD, 0) | 20'h40000, tE, -1);
      end
      default: begin
        w = $urandom_range(0, 3);
        if (ng) begin
          if (w > 0) pushExp(opVec(OP_BOARD, 0), tE + 1, -1);
          ng = 1'b0;
        end
        goTo(tE, 1'b0);
        if (w > 0 && $urandom_range(0, 3) == 0) keyDrv = keyDrv | 5'($urandom_range(1, 31));
        goTo(tE + w, 1'b0);
        go = 1'b1;
        case (op)
          OP_BOARD: nxt = OP_INIT;
          OP_INIT:  nxt = OP_HL;
          OP_HL:    nxt = OP_IDLE;
          OP_CHECK: begin
            h = $urandom_range(0, 1);
            valid_move = 1'(h);
            nxt = (h != 0) ? OP_PLACE : OP_IDLE;
          end
          OP_PLACE: nxt = OP_FLIP;
          OP_FLIP:  nxt = OP_SCORE;
          OP_SCORE: nxt = OP_TURN;
          OP_CUR: begin
            h = passed ? 1 : (nOps > 250) ? 0 : $urandom_range(0, 1);
            passed = 1'b0;
            has_turn = 1'(h);
            nxt = (h != 0) ? OP_HL : OP_OPP;
          end
          OP_OPP: begin
            h = (nOps > 250) ? 0 : $urandom_range(0, 1);
            has_turn = 1'(h);
            passed = (h != 0);
            nxt = (h != 0) ? OP_TURN : OP_REM;
          end
          OP_REM: begin nxt = OP_OVER; games++; end
          default: nxt = OP_RESET;
        endcase
        tE = tE + w + 1;
        op = nxt;
        pushOp(op, tE);
      end
    endcase
  endtask

  // Monitor: every change of the observed vector must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (monOn && obs !== prevObs) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_change cyc=%0d got=%b required=no change", cyc, obs);
      end else begin
        e = q.pop_front();
        if (obs !== e.vec || cyc != e.t || (e.st >= 0 && int'(state_o) != e.st)) begin
          fails++;
          $display("FAIL output_change cyc=%0d got vec=%b state=%0d required vec=%b cyc=%0d state=%0d",
                   cyc, obs, state_o, e.vec, e.t, e.st);
        end
      end
    end
    prevObs = obs;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=no finish required=finish", cyc);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; keyDrv = '0; go = 1'b0; valid_move = 1'b0; has_turn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (obs !== 20'h0 || state_o !== 4'd0) begin
      fails++;
      $display("FAIL reset_state got vec=%b state=%0d required vec=0 state=0", obs, state_o);
    end
    monOn  = 1'b1;
    resetn = 1'b1;
    op = OP_BOARD;
    tE = cyc + 1;
    pushOp(op, tE);

    while (!(op == OP_OVER && games >= 2) && nOps < 2000) runOp();

    // Restart from GAME_OVER, then abort DRAW_BOARD with a mid-operation reset.
    goTo(tE, 1'b1);
    keyDrv = '0;
    goTo(tE + 2, 1'b1);
    keyDrv = 5'b00001;
    tE = tE + 4;
    pushExp(opVec(OP_BOARD, 0) | 20'h40000, tE, -1);
    pushExp(opVec(OP_BOARD, 0), tE + 1, -1);
    pushExp(20'h0, tE + 2, int'(S_RESET));
    goTo(tE + 1, 1'b0);
    resetn = 1'b0;
    keyDrv = '0;
    pushExp(opVec(OP_BOARD, 0), tE + 4, -1);
    goTo(tE + 3, 1'b0);
    resetn = 1'b1;
    tE = tE + 4;
    op = OP_BOARD;
    while (op != OP_IDLE) runOp();

    // Enter into CHECK, then withhold go.
    goTo(tE, 1'b1);
    keyDrv = '0;
    goTo(tE + 1, 1'b1);
    keyDrv = 5'b00001;
    tE = tE + 3;
    op = OP_CHECK;
    pushOp(op, tE);
`ifdef GAME_CONTROL_TIMEOUT_EN
    terrExp = 1'b1;
    pushOp(OP_IDLE, tE + 16);
    terrExp = 1'b0;
    pushExp(20'h0, tE + 19, int'(S_RESET));
    goTo(tE + 18, 1'b0);
    resetn = 1'b0;
`else
    goTo(tE + 20, 1'b0);
    tests++;
    if (state_o !== S_CHECK || check_valid_move_en !== 1'b1) begin
      fails++;
      $display("FAIL check_holds got state=%0d en=%b required state=%0d en=1",
               state_o, check_valid_move_en, S_CHECK);
    end
    pushExp(20'h0, tE + 21, int'(S_RESET));
    resetn = 1'b0;
`endif
    keyDrv = '0;
    goTo(cyc + 4, 1'b0);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_expect got=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
